xadac_axi_responder: RTL and testbench

- AXI slave endpoint for single-beat, word-wide AXI traffic, such as the narrow side of the vector AXI width converter.
- Terminates AXI write and read transactions on a simple request/grant SRAM-style memory port (scratchpad or memory-mapped register file).
- Services one transaction at a time and alternates priority between reads and writes.
- Acts as the responder counterpart for benches and SoC tiles that issue narrow AXI beats.

---
 rtl/xadac_pkg.sv | 24 ++
 rtl/xadac_axi_bus.sv | 47 ++++
 rtl/xadac_axi_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_xadac_axi_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadac_pkg.sv
// Shared types for the xadac vector AXI blocks: AXI id/address/size types,
// AXI response codes and the state encoding of the single-beat AXI responder.
package xadac_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;

    typedef logic [IdWidth-1:0]   IdT;
    typedef logic [AddrWidth-1:0] AddrT;
    typedef logic [2:0]           SizeT;

    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespDecerr = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdWait,
        StRdResp
    } resp_state_e;

endpackage

// File: rtl/xadac_axi_bus.sv
// Single-beat AXI bus bundle carrying the channel fields the xadac blocks use.
interface AXI_BUS #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned UserWidth = 1
);
    import xadac_pkg::*;

    IdT                     aw_id;
    AddrT                   aw_addr;
    logic                   aw_valid;
    logic                   aw_ready;
    logic [DataWidth-1:0]   w_data;
    logic [DataWidth/8-1:0] w_strb;
    logic                   w_valid;
    logic                   w_ready;
    IdT                     b_id;
    logic [1:0]             b_resp;
    logic [UserWidth-1:0]   b_user;
    logic                   b_valid;
    logic                   b_ready;
    IdT                     ar_id;
    AddrT                   ar_addr;
    logic                   ar_valid;
    logic                   ar_ready;
    IdT                     r_id;
    logic [DataWidth-1:0]   r_data;
    logic [1:0]             r_resp;
    logic                   r_last;
    logic [UserWidth-1:0]   r_user;
    logic                   r_valid;
    logic                   r_ready;

    modport Slave (
        input  aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  ar_id, ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid
    );

    modport Master (
        output aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        output ar_id, ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid
    );

endinterface

// File: rtl/xadac_axi_responder.sv
// Single-beat AXI slave terminating reads and writes on a req/gnt SRAM port.
// One transaction in flight; reads and writes alternate when both are pending.
// Optional build macro: XADAC_AXI_RESPONDER_RANGE_CHECK_EN answers addresses outside
// [BaseAddr, BaseAddr+RegionBytes) with DECERR without touching memory.
module xadac_axi_responder
    import xadac_pkg::*;
#(
    parameter int unsigned     DataWidth    = 32,
    parameter int unsigned     MemAddrWidth = 16,
    parameter AddrT            BaseAddr     = '0,
    parameter longint unsigned RegionBytes  = 64'd262144
) (
    input  logic                    clk,
    input  logic                    rstn,
    AXI_BUS.Slave                   slv,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [MemAddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0]    mem_wdata,
    output logic [DataWidth/8-1:0]  mem_strb,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DataWidth-1:0]    mem_rdata
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);

    typedef logic [DataWidth-1:0]    data_t;
    typedef logic [StrbWidth-1:0]    strb_t;
    typedef logic [MemAddrWidth-1:0] maddr_t;

    // Byte offset below the word is dropped; the word index wraps at the memory size.
    function automatic maddr_t word_addr(AddrT a);
        AddrT rel;
        rel = (a - BaseAddr) >> OffWidth;
        return rel[MemAddrWidth-1:0];
    endfunction

    resp_state_e state_q;
    logic   prio_rd_q;
    logic   aw_held_q, w_held_q, ar_held_q;
    logic   aw_ready_q, w_ready_q, ar_ready_q;
    IdT     aw_id_q, ar_id_q;
    AddrT   aw_addr_q, ar_addr_q;
    data_t  w_data_q;
    strb_t  w_strb_q;
    logic   mem_req_q, mem_we_q;
    maddr_t mem_addr_q;
    data_t  mem_wdata_q;
    strb_t  mem_strb_q;
    logic   b_valid_q, r_valid_q;
    IdT     b_id_q, r_id_q;
    logic [1:0] b_resp_q, r_resp_q;
    data_t  r_data_q;

    logic   aw_hs, w_hs, ar_hs;
    logic   aw_held_n, w_held_n, ar_held_n;
    IdT     aw_id_n, ar_id_n;
    AddrT   aw_addr_n, ar_addr_n;
    data_t  w_data_n;
    strb_t  w_strb_n;
    logic   start_wr, start_rd, wr_grant, rd_grant, wr_oor, rd_oor;
    logic   aw_held_d, w_held_d, ar_held_d;

`ifdef XADAC_AXI_RESPONDER_RANGE_CHECK_EN
    typedef logic [AddrWidth:0] ext_addr_t;
    localparam ext_addr_t RegionEnd = ext_addr_t'(BaseAddr) + ext_addr_t'(RegionBytes);

    function automatic logic out_of_range(AddrT a);
        return (ext_addr_t'(a) < ext_addr_t'(BaseAddr)) || (ext_addr_t'(a) >= RegionEnd);
    endfunction

    assign wr_oor = out_of_range(aw_addr_n);
    assign rd_oor = out_of_range(ar_addr_n);
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    // Latch contents including this cycle's handshakes, and the FSM start/clear decisions.
    // IDLE looks at the post-handshake view so a beat accepted now starts next cycle.
    always_comb begin
        aw_hs     = slv.aw_valid & aw_ready_q;
        w_hs      = slv.w_valid & w_ready_q;
        ar_hs     = slv.ar_valid & ar_ready_q;
        aw_held_n = aw_held_q | aw_hs;
        w_held_n  = w_held_q | w_hs;
        ar_held_n = ar_held_q | ar_hs;
        aw_id_n   = aw_hs ? slv.aw_id : aw_id_q;
        aw_addr_n = aw_hs ? slv.aw_addr : aw_addr_q;
        w_data_n  = w_hs ? slv.w_data : w_data_q;
        w_strb_n  = w_hs ? slv.w_strb : w_strb_q;
        ar_id_n   = ar_hs ? slv.ar_id : ar_id_q;
        ar_addr_n = ar_hs ? slv.ar_addr : ar_addr_q;

        start_wr  = (state_q == StIdle) & aw_held_n & w_held_n & (~ar_held_n | ~prio_rd_q);
        start_rd  = (state_q == StIdle) & ar_held_n & ~start_wr;
        wr_grant  = (state_q == StWrReq) & mem_gnt;
        rd_grant  = (state_q == StRdReq) & mem_gnt;

        aw_held_d = aw_held_n & ~(wr_grant | (start_wr & wr_oor));
        w_held_d  = w_held_n & ~(wr_grant | (start_wr & wr_oor));
        ar_held_d = ar_held_n & ~(rd_grant | (start_rd & rd_oor));
    end

    // Input latches, registered readies, and the transaction FSM with its registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            prio_rd_q   <= 1'b0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            ar_held_q   <= 1'b0;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            ar_ready_q  <= 1'b0;
            aw_id_q     <= '0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            ar_id_q     <= '0;
            ar_addr_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_strb_q  <= '0;
            b_valid_q   <= 1'b0;
            b_id_q      <= '0;
            b_resp_q    <= AxiRespOkay;
            r_valid_q   <= 1'b0;
            r_id_q      <= '0;
            r_data_q    <= '0;
            r_resp_q    <= AxiRespOkay;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            ar_held_q  <= ar_held_d;
            aw_ready_q <= ~aw_held_d;
            w_ready_q  <= ~w_held_d;
            ar_ready_q <= ~ar_held_d;
            aw_id_q    <= aw_id_n;
            aw_addr_q  <= aw_addr_n;
            w_data_q   <= w_data_n;
            w_strb_q   <= w_strb_n;
            ar_id_q    <= ar_id_n;
            ar_addr_q  <= ar_addr_n;

            unique case (state_q)
                StIdle: begin
                    if (start_wr) begin
                        prio_rd_q <= ~prio_rd_q;
                        if (wr_oor) begin
                            state_q   <= StWrResp;
                            b_valid_q <= 1'b1;
                            b_id_q    <= aw_id_n;
                            b_resp_q  <= AxiRespDecerr;
                        end else begin
                            state_q     <= StWrReq;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= word_addr(aw_addr_n);
                            mem_wdata_q <= w_data_n;
                            mem_strb_q  <= w_strb_n;
                        end
                    end else if (start_rd) begin
                        prio_rd_q <= ~prio_rd_q;
                        if (rd_oor) begin
                            state_q   <= StRdResp;
                            r_valid_q <= 1'b1;
                            r_id_q    <= ar_id_n;
                            r_data_q  <= '0;
                            r_resp_q  <= AxiRespDecerr;
                        end else begin
                            state_q     <= StRdReq;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= word_addr(ar_addr_n);
                            mem_wdata_q <= '0;
                            mem_strb_q  <= '0;
                        end
                    end
                end
                StWrReq: begin
                    if (mem_gnt) begin
                        state_q   <= StWrResp;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        b_valid_q <= 1'b1;
                        b_id_q    <= aw_id_q;
                        b_resp_q  <= AxiRespOkay;
                    end
                end
                StWrResp: begin
                    if (slv.b_ready) begin
                        state_q   <= StIdle;
                        b_valid_q <= 1'b0;
                    end
                end
                StRdReq: begin
                    if (mem_gnt) begin
                        state_q   <= StRdWait;
                        mem_req_q <= 1'b0;
                        // The AR latch may refill after the grant, so keep the id here.
                        r_id_q    <= ar_id_q;
                    end
                end
                StRdWait: begin
                    if (mem_rvalid) begin
                        state_q   <= StRdResp;
                        r_valid_q <= 1'b1;
                        r_data_q  <= mem_rdata;
                        r_resp_q  <= AxiRespOkay;
                    end
                end
                StRdResp: begin
                    if (slv.r_ready) begin
                        state_q   <= StIdle;
                        r_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign slv.aw_ready = aw_ready_q;
    assign slv.w_ready  = w_ready_q;
    assign slv.ar_ready = ar_ready_q;
    assign slv.b_valid  = b_valid_q;
    assign slv.b_id     = b_id_q;
    assign slv.b_resp   = b_resp_q;
    assign slv.b_user   = '0;
    assign slv.r_valid  = r_valid_q;
    assign slv.r_id     = r_id_q;
    assign slv.r_data   = r_data_q;
    assign slv.r_resp   = r_resp_q;
    // Every beat is the last one; tied to r_valid so the bus idles at zero.
    assign slv.r_last   = r_valid_q;
    assign slv.r_user   = '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_strb  = mem_strb_q;

endmodule

// File: tb/tb_xadac_axi_responder.sv
// Directed bench for xadac_axi_responder: vector table of write/read-back pairs plus
// hand-written sequences for ordering, priority, backpressure, range and reset cases.
module tb_xadac_axi_responder;
    import xadac_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    AXI_BUS #(.DataWidth(32)) bus ();

    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;
    logic        gnt_en, model_rvalid, man_rvalid;
    logic [31:0] model_rdata;
    logic [31:0] mem_arr [256];

    assign mem_gnt    = mem_req & gnt_en;
    assign mem_rvalid = model_rvalid | man_rvalid;
    assign mem_rdata  = model_rdata;

    xadac_axi_responder #(
        .DataWidth   (32),
        .MemAddrWidth(16),
        .BaseAddr    (32'h0),
        .RegionBytes (64'd262144)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .slv       (bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_strb  (mem_strb),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    // Memory model: byte-masked writes, read data one cycle after the grant.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_rvalid <= 1'b0;
            model_rdata  <= '0;
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
        end else begin
            model_rvalid <= 1'b0;
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_strb[b]) mem_arr[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end else begin
                    model_rvalid <= 1'b1;
                    model_rdata  <= mem_arr[mem_addr[7:0]];
                end
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic need_wr, input logic need_rd);
        int n = 0;
        while (((need_wr && !(bus.aw_ready && bus.w_ready)) || (need_rd && !bus.ar_ready))
               && n < 20) begin
            tick();
            n++;
        end
        check("ready before issue", 64'(n < 20), 64'd1);
    endtask

    task automatic do_write(input AddrT a, input logic [31:0] d, input logic [3:0] s,
                            input IdT id, input logic [15:0] exp_ma);
        wait_ready(1'b1, 1'b0);
        bus.aw_valid = 1'b1; bus.aw_addr = a; bus.aw_id = id;
        bus.w_valid  = 1'b1; bus.w_data = d;  bus.w_strb = s;
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        check("wr mem_req/we", {mem_req, mem_we}, 2'b11);
        check("wr mem_addr", mem_addr, exp_ma);
        check("wr mem_wdata/strb", {mem_wdata, mem_strb}, {d, s});
        check("wr w_ready held low", bus.w_ready, 1'b0);
        tick();
        check("wr b_valid/id/resp", {bus.b_valid, bus.b_id, bus.b_resp}, {1'b1, id, 2'b00});
        check("wr aw_ready back", bus.aw_ready, 1'b1);
        tick();
    endtask

    task automatic do_read(input AddrT a, input IdT id, input logic [15:0] exp_ma,
                           input logic [31:0] exp_d);
        wait_ready(1'b0, 1'b1);
        bus.ar_valid = 1'b1; bus.ar_addr = a; bus.ar_id = id;
        tick();
        bus.ar_valid = 1'b0;
        check("rd mem_req/we", {mem_req, mem_we}, 2'b10);
        check("rd mem_addr", mem_addr, exp_ma);
        tick();
        check("rd wait no r_valid", bus.r_valid, 1'b0);
        tick();
        check("rd r_valid/last/id/resp", {bus.r_valid, bus.r_last, bus.r_id, bus.r_resp},
              {1'b1, 1'b1, id, 2'b00});
        check("rd r_data", bus.r_data, exp_d);
        tick();
    endtask

    task automatic issue_all(input AddrT wa, input logic [31:0] wd, input IdT wid,
                             input AddrT ra, input IdT rid);
        wait_ready(1'b1, 1'b1);
        bus.aw_valid = 1'b1; bus.aw_addr = wa; bus.aw_id = wid;
        bus.w_valid  = 1'b1; bus.w_data = wd;  bus.w_strb = 4'hF;
        bus.ar_valid = 1'b1; bus.ar_addr = ra; bus.ar_id = rid;
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    endtask

    typedef struct {
        AddrT        addr;
        logic [31:0] data;
        logic [3:0]  strb;
        IdT          id;
        logic [15:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 4'd1, 16'h0010, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0043, 32'h0000_AB00, 4'h2, 4'd2, 16'h0010, 32'hDEAD_ABEF};
        vecs[2] = '{32'h0000_0044, 32'h1234_5678, 4'h9, 4'd3, 16'h0011, 32'h1200_0078};
        vecs[3] = '{32'h0003_FFFC, 32'hA5A5_A5A5, 4'hF, 4'd4, 16'hFFFF, 32'hA5A5_A5A5};
        vecs[4] = '{32'h0000_0000, 32'hCAFE_F00D, 4'h3, 4'd5, 16'h0000, 32'h0000_F00D};

        bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0;
        bus.w_valid = 0;  bus.w_data = '0; bus.w_strb = '0;
        bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0;
        bus.b_ready = 1;  bus.r_ready = 1;
        gnt_en = 1; man_rvalid = 0;

        // Reset state
        repeat (2) tick();
        check("reset readies", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
        check("reset valids/mem_req", {bus.b_valid, bus.r_valid, bus.r_last, mem_req}, 4'b0);
        check("reset buses", {mem_addr, mem_wdata, mem_strb, bus.r_data}, '0);
        rstn = 1'b1;
        tick();

        // Vector table: write then read back each entry
        for (int i = 0; i < 5; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].id, vecs[i].exp_maddr);
            do_read(vecs[i].addr, vecs[i].id + 4'd1, vecs[i].exp_maddr, vecs[i].exp_rdata);
        end

        // W before AW: write starts only after AW arrives
        wait_ready(1'b1, 1'b0);
        bus.w_valid = 1'b1; bus.w_data = 32'h0BAD_F00D; bus.w_strb = 4'hF;
        tick();
        bus.w_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check("w-first w_ready low", bus.w_ready, 1'b0);
            check("w-first no mem_req", mem_req, 1'b0);
            if (c == 3) begin
                bus.aw_valid = 1'b1; bus.aw_addr = 32'h100; bus.aw_id = 4'd9;
            end
            tick();
        end
        bus.aw_valid = 1'b0;
        check("w-first mem_req/we/addr", {mem_req, mem_we, mem_addr}, {2'b11, 16'h0040});
        tick();
        check("w-first b_valid/id", {bus.b_valid, bus.b_id}, {1'b1, 4'd9});
        tick();
        do_read(32'h100, 4'd10, 16'h0040, 32'h0BAD_F00D);

        // Simultaneous pending: write wins first
        issue_all(32'h80, 32'h1111_1111, 4'd6, 32'h40, 4'd7);
        check("sim1 c1 write", {mem_req, mem_we, mem_addr}, {2'b11, 16'h0020});
        tick();
        check("sim1 c2 b_valid/id", {bus.b_valid, bus.b_id}, {1'b1, 4'd6});
        check("sim1 c2 ar still held", bus.ar_ready, 1'b0);
        repeat (2) tick();
        check("sim1 c4 read", {mem_req, mem_we, mem_addr}, {2'b10, 16'h0010});
        repeat (2) tick();
        check("sim1 c6 r", {bus.r_valid, bus.r_id, bus.r_data}, {1'b1, 4'd7, 32'hDEAD_ABEF});
        tick();

        // After a lone write, a simultaneous pair serves the read first
        do_write(32'h80, 32'h2222_2222, 4'hF, 4'd1, 16'h0020);
        issue_all(32'h80, 32'h3333_3333, 4'd2, 32'h80, 4'd3);
        check("sim2 c1 read", {mem_req, mem_we, mem_addr}, {2'b10, 16'h0020});
        repeat (2) tick();
        check("sim2 c3 r", {bus.r_valid, bus.r_id, bus.r_data}, {1'b1, 4'd3, 32'h2222_2222});
        check("sim2 c3 w held", bus.w_ready, 1'b0);
        repeat (2) tick();
        check("sim2 c5 write", {mem_req, mem_we, mem_wdata}, {2'b11, 32'h3333_3333});
        tick();
        check("sim2 c6 b", {bus.b_valid, bus.b_id}, {1'b1, 4'd2});
        tick();

        // Backpressure on grant, then on b_ready with a read waiting
        wait_ready(1'b1, 1'b1);
        gnt_en = 1'b0; bus.b_ready = 1'b0;
        bus.aw_valid = 1'b1; bus.aw_addr = 32'hC0; bus.aw_id = 4'd7;
        bus.w_valid = 1'b1;  bus.w_data = 32'h5A5A_0F0F; bus.w_strb = 4'hF;
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        bus.ar_valid = 1'b1; bus.ar_addr = 32'hC0; bus.ar_id = 4'd8;
        for (int i = 0; i < 5; i++) begin
            check("gnt stall mem stable", {mem_req, mem_we, mem_addr, mem_wdata, mem_strb},
                  {2'b11, 16'h0030, 32'h5A5A_0F0F, 4'hF});
            tick();
            bus.ar_valid = 1'b0;
        end
        gnt_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("b stall stable", {bus.b_valid, bus.b_id, mem_req}, {1'b1, 4'd7, 1'b0});
            tick();
        end
        bus.b_ready = 1'b1;
        tick();
        check("b released", bus.b_valid, 1'b0);
        tick();
        check("queued read issued", {mem_req, mem_we, mem_addr}, {2'b10, 16'h0030});
        repeat (2) tick();
        check("queued read r", {bus.r_valid, bus.r_id, bus.r_data}, {1'b1, 4'd8, 32'h5A5A_0F0F});
        tick();

`ifdef XADAC_AXI_RESPONDER_RANGE_CHECK_EN
        // Out-of-region read and write bypass memory with DECERR
        wait_ready(1'b0, 1'b1);
        bus.ar_valid = 1'b1; bus.ar_addr = 32'h0004_0000; bus.ar_id = 4'd9;
        tick();
        bus.ar_valid = 1'b0;
        check("oor rd r", {bus.r_valid, bus.r_id, bus.r_resp, bus.r_data},
              {1'b1, 4'd9, 2'b11, 32'h0});
        check("oor rd no mem_req, ar_ready", {mem_req, bus.ar_ready}, 2'b01);
        tick();
        wait_ready(1'b1, 1'b0);
        bus.aw_valid = 1'b1; bus.aw_addr = 32'h0004_0008; bus.aw_id = 4'd3;
        bus.w_valid = 1'b1;  bus.w_data = 32'h7777_7777; bus.w_strb = 4'hF;
        tick();
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        check("oor wr b", {bus.b_valid, bus.b_id, bus.b_resp, mem_req}, {1'b1, 4'd3, 2'b11, 1'b0});
        tick();
`else
        // Without range checking the word address wraps at the memory size
        do_write(32'h0004_0008, 32'h7777_7777, 4'hF, 4'd3, 16'h0002);
        do_read(32'h8, 4'd4, 16'h0002, 32'h7777_7777);
`endif

        // Reset while waiting for read data; late rvalid is ignored
        wait_ready(1'b0, 1'b1);
        bus.ar_valid = 1'b1; bus.ar_addr = 32'h40; bus.ar_id = 4'd5;
        tick();
        bus.ar_valid = 1'b0;
        tick();
        rstn = 1'b0;
        man_rvalid = 1'b1;
        #1;
        check("mid-reset outputs", {bus.r_valid, bus.b_valid, mem_req, bus.ar_ready, bus.r_data},
              '0);
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        check("post-reset no r_valid", {bus.r_valid, bus.r_id, bus.r_data, mem_req}, '0);
        man_rvalid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
